// File: rtl/csel_pipe_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : csel_pipe_subtractor                                         |
// | Description : Two-stage pipelined carry-select subtractor,                 |
// |               D = A - B - Bin, computed as A + ~B + ~Bin over 5/7/9/11     |
// |               segments. It uses a valid/ready elastic handshake that       |
// |               tolerates downstream back-pressure.                          |
// | Options     : `define CSEL_SAT_EN -> D saturates on signed overflow        |
// |               (V and Bout are unaffected). When it is not defined, D wraps |
// |               modulo 2^WIDTH.                                              |
// | Ports       : clk        in   clock, rising edge                           |
// |               rst_n      in   asynchronous active-low reset                |
// |               in_valid   in   A/B/Bin valid                                |
// |               in_ready   out  stage 1 can accept this cycle                |
// |               A, B       in   minuend / subtrahend (WIDTH)                 |
// |               Bin        in   borrow-in                                    |
// |               out_valid  out  D/Bout/V valid                               |
// |               out_ready  in   consumer accepts D/Bout/V                    |
// |               D          out  difference (registered, WIDTH)               |
// |               Bout       out  borrow-out, ~carry-out (registered)          |
// |               V          out  signed overflow (registered)                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module csel_pipe_subtractor #(
  parameter  int SEG0_W = 5,
  parameter  int SEG1_W = 7,
  parameter  int SEG2_W = 9,
  parameter  int SEG3_W = 11,
  localparam int WIDTH  = SEG0_W + SEG1_W + SEG2_W + SEG3_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
);

  localparam int c_LO1 = SEG0_W;
  localparam int c_LO2 = SEG0_W + SEG1_W;
  localparam int c_LO3 = SEG0_W + SEG1_W + SEG2_W;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic r_s1_valid;
  logic r_out_valid;
  logic w_adv1;
  logic w_adv2;

  assign w_adv2    = ~r_out_valid | out_ready;
  assign w_adv1    = ~r_s1_valid | w_adv2;
  assign in_ready  = w_adv1;
  assign out_valid = r_out_valid;

  // ---------------------------------------------------------------------------
  // Stage 1 combinational: segment 0 ripples with the real carry-in. Each
  // upper segment produces both carry-in candidates, so stage 2 only needs a
  // short mux chain.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]  w_bn;
  logic [SEG0_W:0]   w_seg0;
  logic [SEG1_W:0]   w_seg1_c0, w_seg1_c1;
  logic [SEG2_W:0]   w_seg2_c0, w_seg2_c1;
  logic [SEG3_W:0]   w_seg3_c0, w_seg3_c1;

  assign w_bn = ~B;

  assign w_seg0 = {1'b0, A[c_LO1-1:0]} + {1'b0, w_bn[c_LO1-1:0]}
                + {{SEG0_W{1'b0}}, ~Bin};

  assign w_seg1_c0 = {1'b0, A[c_LO2-1:c_LO1]} + {1'b0, w_bn[c_LO2-1:c_LO1]};
  assign w_seg1_c1 = {1'b0, A[c_LO2-1:c_LO1]} + {1'b0, w_bn[c_LO2-1:c_LO1]}
                   + {{SEG1_W{1'b0}}, 1'b1};

  assign w_seg2_c0 = {1'b0, A[c_LO3-1:c_LO2]} + {1'b0, w_bn[c_LO3-1:c_LO2]};
  assign w_seg2_c1 = {1'b0, A[c_LO3-1:c_LO2]} + {1'b0, w_bn[c_LO3-1:c_LO2]}
                   + {{SEG2_W{1'b0}}, 1'b1};

  assign w_seg3_c0 = {1'b0, A[WIDTH-1:c_LO3]} + {1'b0, w_bn[WIDTH-1:c_LO3]};
  assign w_seg3_c1 = {1'b0, A[WIDTH-1:c_LO3]} + {1'b0, w_bn[WIDTH-1:c_LO3]}
                   + {{SEG3_W{1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  logic [SEG0_W-1:0] r_s0;
  logic              r_c5;
  logic [SEG1_W:0]   r_seg1_c0, r_seg1_c1;
  logic [SEG2_W:0]   r_seg2_c0, r_seg2_c1;
  logic [SEG3_W:0]   r_seg3_c0, r_seg3_c1;
  logic              r_a_msb;
  logic              r_b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s0       <= '0;
      r_c5       <= 1'b0;
      r_seg1_c0  <= '0;
      r_seg1_c1  <= '0;
      r_seg2_c0  <= '0;
      r_seg2_c1  <= '0;
      r_seg3_c0  <= '0;
      r_seg3_c1  <= '0;
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
      // Data only moves with a real transfer, which avoids needless toggling.
      if (in_valid) begin
        r_s0      <= w_seg0[SEG0_W-1:0];
        r_c5      <= w_seg0[SEG0_W];
        r_seg1_c0 <= w_seg1_c0;
        r_seg1_c1 <= w_seg1_c1;
        r_seg2_c0 <= w_seg2_c0;
        r_seg2_c1 <= w_seg2_c1;
        r_seg3_c0 <= w_seg3_c0;
        r_seg3_c1 <= w_seg3_c1;
        r_a_msb   <= A[WIDTH-1];
        r_b_msb   <= B[WIDTH-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 combinational: carry-select mux chain
  // ---------------------------------------------------------------------------
  logic [SEG1_W:0]  w_sel1;
  logic [SEG2_W:0]  w_sel2;
  logic [SEG3_W:0]  w_sel3;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_d_next;
  logic             w_ovf;

  assign w_sel1 = r_c5           ? r_seg1_c1 : r_seg1_c0;
  assign w_sel2 = w_sel1[SEG1_W] ? r_seg2_c1 : r_seg2_c0;
  assign w_sel3 = w_sel2[SEG2_W] ? r_seg3_c1 : r_seg3_c0;

  assign w_diff = {w_sel3[SEG3_W-1:0], w_sel2[SEG2_W-1:0],
                   w_sel1[SEG1_W-1:0], r_s0};

  // Subtraction overflows only when the operand signs differ and the result
  // sign disagrees with the minuend.
  assign w_ovf = (r_a_msb != r_b_msb) && (w_diff[WIDTH-1] != r_a_msb);

`ifdef CSEL_SAT_EN
  assign w_d_next = !w_ovf  ? w_diff :
                    r_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} :
                              {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign w_d_next = w_diff;
`endif

  // ---------------------------------------------------------------------------
  // Output stage registers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_d         <= '0;
      r_bout      <= 1'b0;
      r_v         <= 1'b0;
    end else if (w_adv2) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_d    <= w_d_next;
        r_bout <= ~w_sel3[SEG3_W];
        r_v    <= w_ovf;
      end
    end
  end

  assign D    = r_d;
  assign Bout = r_bout;
  assign V    = r_v;

endmodule
`default_nettype wire

// File: tb/tb_csel_pipe_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_csel_pipe_subtractor                                      |
// | Description : Directed self-checking bench for csel_pipe_subtractor.       |
// |               The expected values below are computed by hand.             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_csel_pipe_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        Bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] D;
  logic        Bout;
  logic        V;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  csel_pipe_subtractor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .Bout      (Bout),
    .V         (V)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction with no stall: accept, one more edge, then the result is visible.
  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic bin, input logic [31:0] exp_d,
                         input logic exp_bout, input logic exp_v);
    A = a; B = b; Bin = bin; in_valid = 1'b1; out_ready = 1'b1;
    check({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check({tag, ".lat1_valid"}, {31'b0, out_valid}, 32'd0);
    tick();
    check({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, ".D"},     D,                  exp_d);
    check({tag, ".Bout"},  {31'b0, Bout},      {31'b0, exp_bout});
    check({tag, ".V"},     {31'b0, V},         {31'b0, exp_v});
    tick();
    check({tag, ".drained"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; Bin = 1'b0; out_ready = 1'b1;
    #2;
    check("rst.valid",    {31'b0, out_valid}, 32'd0);
    check("rst.D",        D,                  32'd0);
    check("rst.Bout",     {31'b0, Bout},      32'd0);
    check("rst.V",        {31'b0, V},         32'd0);
    check("rst.in_ready", {31'b0, in_ready},  32'd1);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic and wrap cases
    run_one("t1_5m3",  32'd5,          32'd3,          1'b0, 32'd2,          1'b0, 1'b0);
    run_one("t2_0m1",  32'd0,          32'd1,          1'b0, 32'hFFFF_FFFF,  1'b1, 1'b0);
`ifdef CSEL_SAT_EN
    run_one("t3_ovf",  32'h8000_0000,  32'd1,          1'b0, 32'h8000_0000,  1'b0, 1'b1);
    run_one("t3_ovfp", 32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'h7FFF_FFFF,  1'b1, 1'b1);
`else
    run_one("t3_ovf",  32'h8000_0000,  32'd1,          1'b0, 32'h7FFF_FFFF,  1'b0, 1'b1);
    run_one("t3_ovfp", 32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000,  1'b1, 1'b1);
`endif
    // Borrows that ripple across segment boundaries
    run_one("t4_b5",   32'h20,         32'd1,          1'b0, 32'h1F,         1'b0, 1'b0);
    run_one("t4_b12",  32'h1000,       32'd1,          1'b0, 32'hFFF,        1'b0, 1'b0);
    run_one("t4_b21",  32'h20_0000,    32'd0,          1'b1, 32'h1F_FFFF,    1'b0, 1'b0);
    run_one("t4_bin0", 32'd0,          32'd0,          1'b1, 32'hFFFF_FFFF,  1'b1, 1'b0);

    // Back-pressure: out_ready low for 4 edges while 3 inputs are offered
    out_ready = 1'b0;
    A = 32'd100;  B = 32'd1;   Bin = 1'b0; in_valid = 1'b1;   // X1 = 99
    tick();
    check("t5.ready_x2", {31'b0, in_ready}, 32'd1);
    A = 32'h1000; B = 32'h10;                                 // X2 = 0xFF0
    tick();
    A = 32'd10;   B = 32'd20;                                 // X3 = -10
    check("t5.full_ready", {31'b0, in_ready},  32'd0);
    check("t5.valid",      {31'b0, out_valid}, 32'd1);
    check("t5.D_x1",       D,                  32'd99);
    tick();
    check("t5.stall_D1",     D,                  32'd99);
    check("t5.stall_ready1", {31'b0, in_ready}, 32'd0);
    tick();
    check("t5.stall_D2",     D,                  32'd99);
    check("t5.stall_valid2", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    #1;
    check("t5.ready_release", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("t5.D_x2",  D,             32'hFF0);
    check("t5.v_x2",  {31'b0, out_valid}, 32'd1);
    tick();
    check("t5.D_x3",    D,             32'hFFFF_FFF6);
    check("t5.Bout_x3", {31'b0, Bout}, 32'd1);
    tick();
    check("t5.empty", {31'b0, out_valid}, 32'd0);

    // Reset with two results in flight
    out_ready = 1'b1;
    A = 32'd7; B = 32'd2; Bin = 1'b0; in_valid = 1'b1;
    tick();
    A = 32'd9; B = 32'd4;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6.rst_valid", {31'b0, out_valid}, 32'd0);
    check("t6.rst_D",     D,                  32'd0);
    check("t6.rst_ready", {31'b0, in_ready},  32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6.no_ghost", {31'b0, out_valid}, 32'd0);
    run_one("t6_after", 32'h1234_5678, 32'h0000_5678, 1'b0, 32'h1234_0000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
